// File: rtl/scratch_pad_loader_pkg.sv
// Shared types and constants for the scratch pad write-side loader.
package scratch_pad_loader_pkg;

    localparam int unsigned LAYER_W           = 3;
    localparam int unsigned STEP_W            = 3;
    localparam int unsigned ENTRIES_PER_LAYER = 2;

    localparam logic [STEP_W-1:0] STEP_IDLE = 3'd0;
    localparam logic [STEP_W-1:0] STEP_ACT  = 3'd1;
    localparam logic [STEP_W-1:0] STEP_WGT  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_ACT,
        ST_LOAD_WGT,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/scratch_pad_loader_if.sv
// Valid/ready word stream from the packet receiver into the loader.
interface scratch_pad_loader_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/scratch_pad_loader_addr_gen.sv
// Nested addr/num/layer counter walking one BRAM group; last_c flags the final entry.
module loader_addr_gen
    import scratch_pad_loader_pkg::*;
#(
    parameter int unsigned NUM_W     = 6,
    parameter int unsigned NUM_COUNT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    input  logic [LAYER_W-1:0] num_layers,
    output logic               addr,
    output logic [NUM_W-1:0]   num,
    output logic [LAYER_W-1:0] layer,
    output logic               last_c
);
    localparam logic             ADDR_MAX = 1'(ENTRIES_PER_LAYER - 1);
    localparam logic [NUM_W-1:0] NUM_MAX  = NUM_W'(NUM_COUNT - 1);

    assign last_c = (addr == ADDR_MAX) && (num == NUM_MAX)
                 && (layer == num_layers - LAYER_W'(1));

    // Wrapping on the final entry leaves the counter ready for the next phase/load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= 1'b0;
            num   <= '0;
            layer <= '0;
        end else if (clear || (advance && last_c)) begin
            addr  <= 1'b0;
            num   <= '0;
            layer <= '0;
        end else if (advance) begin
            if (addr == ADDR_MAX) begin
                addr <= 1'b0;
                if (num == NUM_MAX) begin
                    num   <= '0;
                    layer <= layer + LAYER_W'(1);
                end else begin
                    num <= num + NUM_W'(1);
                end
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scratch_pad_loader.sv
// Scratch pad write-side driver: sequences a word stream into activation then weight BRAMs.
module scratch_pad_loader
    import scratch_pad_loader_pkg::*;
#(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BUFFER_SIZE = 5,
    parameter int unsigned SYS_WIDTH   = 64,
    parameter int unsigned SYS_HEIGHT  = 1,
    parameter int unsigned ACT_NUM_W   = 1,
    parameter int unsigned WGT_NUM_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LAYER_W-1:0]    num_layers,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    scratch_pad_loader_if.slave   in_if,
    output logic [STEP_W-1:0]     step,
    output logic [ACT_NUM_W-1:0]  act_bram_num,
    output logic                  act_bram_addr,
    output logic [LAYER_W-1:0]    act_bram_layer,
    output logic [WGT_NUM_W-1:0]  weight_bram_num,
    output logic                  weight_bram_addr,
    output logic [LAYER_W-1:0]    weight_bram_layer,
    output logic [WORD_W-1:0]     data_received
);
    state_t               state_q, state_d;
    logic [LAYER_W-1:0]   layers_q;
    logic                 in_ready_q;
    logic                 accept, act_adv, wgt_adv, clear, start_ok, start_bad, finish;
    logic                 act_addr, wgt_addr, act_last, wgt_last;
    logic [ACT_NUM_W-1:0] act_num;
    logic [WGT_NUM_W-1:0] wgt_num;
    logic [LAYER_W-1:0]   act_layer, wgt_layer;

    assign in_if.in_ready = in_ready_q;

    loader_addr_gen #(.NUM_W(ACT_NUM_W), .NUM_COUNT(SYS_HEIGHT)) u_act_gen (
        .clk, .rst_n, .clear, .advance(act_adv), .num_layers(layers_q),
        .addr(act_addr), .num(act_num), .layer(act_layer), .last_c(act_last)
    );

    loader_addr_gen #(.NUM_W(WGT_NUM_W), .NUM_COUNT(SYS_WIDTH)) u_wgt_gen (
        .clk, .rst_n, .clear, .advance(wgt_adv), .num_layers(layers_q),
        .addr(wgt_addr), .num(wgt_num), .layer(wgt_layer), .last_c(wgt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = in_if.in_valid & in_ready_q;
        act_adv   = 1'b0;
        wgt_adv   = 1'b0;
        clear     = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((num_layers != '0) && (32'(num_layers) <= BUFFER_SIZE)) begin
                        start_ok = 1'b1;
                        clear    = 1'b1;
                        state_d  = ST_LOAD_ACT;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            ST_LOAD_ACT: begin
                if (accept) begin
                    act_adv = 1'b1;
                    if (act_last) state_d = ST_LOAD_WGT;
                end
            end
            ST_LOAD_WGT: begin
                if (accept) begin
                    wgt_adv = 1'b1;
                    if (wgt_last) begin
                        finish  = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Write fields follow the accepted word by one cycle; data holds across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layers_q          <= '0;
            busy              <= 1'b0;
            in_ready_q        <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            step              <= STEP_IDLE;
            act_bram_num      <= '0;
            act_bram_addr     <= 1'b0;
            act_bram_layer    <= '0;
            weight_bram_num   <= '0;
            weight_bram_addr  <= 1'b0;
            weight_bram_layer <= '0;
            data_received     <= '0;
        end else begin
            if (start_ok) layers_q <= num_layers;
            busy              <= (state_d != ST_IDLE);
            in_ready_q        <= (state_d == ST_LOAD_ACT) || (state_d == ST_LOAD_WGT);
            done              <= finish;
            err               <= start_bad;
            step              <= STEP_IDLE;
            act_bram_num      <= '0;
            act_bram_addr     <= 1'b0;
            act_bram_layer    <= '0;
            weight_bram_num   <= '0;
            weight_bram_addr  <= 1'b0;
            weight_bram_layer <= '0;
            if (act_adv) begin
                step           <= STEP_ACT;
                act_bram_num   <= act_num;
                act_bram_addr  <= act_addr;
                act_bram_layer <= act_layer;
                data_received  <= in_if.in_data;
            end
            if (wgt_adv) begin
                step              <= STEP_WGT;
                weight_bram_num   <= wgt_num;
                weight_bram_addr  <= wgt_addr;
                weight_bram_layer <= wgt_layer;
                data_received     <= in_if.in_data;
            end
        end
    end

endmodule

// File: tb/tb_scratch_pad_loader.sv
// Randomized bench for scratch_pad_loader against a loop-nest model of the write order.
module tb_scratch_pad_loader;

    localparam int SYS_W = 64;
    localparam int SYS_H = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  num_layers = 3'd0;
    logic        busy, done, err;
    logic [2:0]  step;
    logic [0:0]  act_bram_num;
    logic        act_bram_addr;
    logic [2:0]  act_bram_layer;
    logic [5:0]  weight_bram_num;
    logic        weight_bram_addr;
    logic [2:0]  weight_bram_layer;
    logic [31:0] data_received;

    scratch_pad_loader_if #(.WORD_W(32)) sp_if ();

    scratch_pad_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_layers(num_layers),
        .busy(busy), .done(done), .err(err), .in_if(sp_if),
        .step(step), .act_bram_num(act_bram_num), .act_bram_addr(act_bram_addr),
        .act_bram_layer(act_bram_layer), .weight_bram_num(weight_bram_num),
        .weight_bram_addr(weight_bram_addr), .weight_bram_layer(weight_bram_layer),
        .data_received(data_received)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          step;
        int          num;
        int          addr;
        int          layer;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         obs[$];
    wr_t         exp_q[$];
    logic [31:0] words[$];
    int compared = 0, mismatched = 0;
    int done_cnt, err_cnt, proto_errs, acc_last_cyc, done_cyc, idle_cyc, sent;
    bit timed_out;

    // Expected write sequence: layer outermost, BRAM number, then entry innermost
    function automatic void build_expected(input int n);
        int idx = 0;
        exp_q.delete();
        for (int l = 0; l < n; l++)
            for (int b = 0; b < SYS_H; b++)
                for (int a = 0; a < 2; a++) begin
                    exp_q.push_back('{1, b, a, l, words[idx], 0});
                    idx++;
                end
        for (int l = 0; l < n; l++)
            for (int b = 0; b < SYS_W; b++)
                for (int a = 0; a < 2; a++) begin
                    exp_q.push_back('{2, b, a, l, words[idx], 0});
                    idx++;
                end
    endfunction

    function automatic int first_diff();
        int n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs[i].step != exp_q[i].step || obs[i].num != exp_q[i].num ||
                obs[i].addr != exp_q[i].addr || obs[i].layer != exp_q[i].layer ||
                obs[i].data !== exp_q[i].data)
                return i;
        return -1;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy !== 1'b0) begin
            compared++; mismatched++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
        end
    endtask

    // Drives one load (mode 0 held valid, 1 alternating, 2 random) and records every write
    task automatic run_load(input int n, input int mode, input int glitch_at, input int abort_at);
        int  total = 2 * (SYS_H + SYS_W) * n;
        bit  acc, prev_acc = 0, glitched = 0;
        wr_t w;
        obs.delete(); words.delete();
        for (int i = 0; i < total; i++) words.push_back($urandom);
        done_cnt = 0; err_cnt = 0; proto_errs = 0; sent = 0; timed_out = 0;
        acc_last_cyc = -1; done_cyc = -1; idle_cyc = -1;
        start = 1'b1; num_layers = 3'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (abort_at >= 0 && sent == abort_at) begin
                sp_if.in_valid = 1'b0;
                return;
            end
            sp_if.in_valid = (sent < total) &&
                             (mode == 0 || (mode == 1 && c % 2 == 0) ||
                              (mode == 2 && $urandom_range(0, 1) == 1));
            sp_if.in_data  = (sent < total) ? words[sent] : $urandom;
            if (glitch_at >= 0 && sent == glitch_at && !glitched) begin
                glitched = 1; start = 1'b1; num_layers = 3'($urandom_range(1, 5));
            end
            @(negedge clk);
            if (step != 3'd0) begin
                w.step = int'(step); w.data = data_received; w.cyc = c;
                if (step == 3'd1) begin
                    w.num = int'(act_bram_num); w.addr = int'(act_bram_addr); w.layer = int'(act_bram_layer);
                    if (weight_bram_num != 0 || weight_bram_addr || weight_bram_layer != 0) proto_errs++;
                end else begin
                    w.num = int'(weight_bram_num); w.addr = int'(weight_bram_addr); w.layer = int'(weight_bram_layer);
                    if (act_bram_num != 0 || act_bram_addr || act_bram_layer != 0) proto_errs++;
                end
                obs.push_back(w);
                if (!prev_acc) proto_errs++;
            end else if (prev_acc) proto_errs++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (err) err_cnt++;
            if (done_cyc >= 0 && !busy && idle_cyc < 0) idle_cyc = c;
            acc = sp_if.in_valid && sp_if.in_ready;
            if (acc) acc_last_cyc = c;
            prev_acc = acc;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) sent++;
            if (idle_cyc >= 0) break;
        end
        sp_if.in_valid = 1'b0;
        if (idle_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset();
        logic [63:0] snap;
        repeat (2) @(posedge clk);
        #1;
        snap = {step, act_bram_num, act_bram_addr, act_bram_layer, weight_bram_num,
                weight_bram_addr, weight_bram_layer, busy, done, err, sp_if.in_ready, data_received};
        compared++;
        if (snap !== 64'd0) begin
            mismatched++; $display("FAIL reset_outputs: got %h, required 0", snap);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({busy, sp_if.in_ready, step} !== 5'd0) begin
            mismatched++; $display("FAIL post_reset_idle: busy/ready/step=%b, required 0", {busy, sp_if.in_ready, step});
        end
    endtask

    task automatic test_single_layer();
        int d;
        wait_idle();
        run_load(1, 0, -1, -1);
        build_expected(1);
        d = first_diff();
        compared += 6;
        if (obs.size() != 130) begin mismatched++; $display("FAIL single_count: got %0d writes, required 130", obs.size()); end
        if (d != -1) begin mismatched++; $display("FAIL single_order: idx %0d got s%0d n%0d a%0d l%0d %h, required s%0d n%0d a%0d l%0d %h", d,
            obs[d].step, obs[d].num, obs[d].addr, obs[d].layer, obs[d].data,
            exp_q[d].step, exp_q[d].num, exp_q[d].addr, exp_q[d].layer, exp_q[d].data); end
        if (done_cnt != 1) begin mismatched++; $display("FAIL single_done_count: got %0d, required 1", done_cnt); end
        if (done_cyc != acc_last_cyc + 1) begin mismatched++; $display("FAIL single_done_timing: got %0d, required %0d", done_cyc, acc_last_cyc + 1); end
        if (idle_cyc != acc_last_cyc + 2 || timed_out) begin mismatched++; $display("FAIL single_busy_drop: got %0d, required %0d", idle_cyc, acc_last_cyc + 2); end
        if (proto_errs != 0) begin mismatched++; $display("FAIL single_latency: got %0d violations, required 0", proto_errs); end
    endtask

    task automatic test_five_layers_toggle();
        int d;
        wr_t f;
        wait_idle();
        run_load(5, 1, -1, -1);
        build_expected(5);
        d = first_diff();
        compared += 5;
        if (obs.size() != 650) begin mismatched++; $display("FAIL five_count: got %0d writes, required 650", obs.size()); end
        if (d != -1) begin mismatched++; $display("FAIL five_order: idx %0d got s%0d n%0d a%0d l%0d %h, required s%0d n%0d a%0d l%0d %h", d,
            obs[d].step, obs[d].num, obs[d].addr, obs[d].layer, obs[d].data,
            exp_q[d].step, exp_q[d].num, exp_q[d].addr, exp_q[d].layer, exp_q[d].data); end
        if (proto_errs != 0) begin mismatched++; $display("FAIL five_bubbles: got %0d violations, required 0", proto_errs); end
        if (done_cnt != 1 || timed_out) begin mismatched++; $display("FAIL five_done: got %0d (timeout %0d), required 1", done_cnt, timed_out); end
        if (obs.size() > 0) f = obs[obs.size() - 1];
        else f = '{0, 0, 0, 0, 32'd0, 0};
        if (f.step != 2 || f.num != 63 || f.addr != 1 || f.layer != 4) begin
            mismatched++; $display("FAIL five_final_write: got s%0d n%0d a%0d l%0d, required s2 n63 a1 l4", f.step, f.num, f.addr, f.layer);
        end
    endtask

    task automatic test_invalid_start();
        int vals[3] = '{0, 6, 7};
        wait_idle();
        sp_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; num_layers = 3'(vals[i]);
            @(posedge clk); #1;
            start = 1'b0;
            compared += 2;
            if (err !== 1'b1) begin mismatched++; $display("FAIL invalid_err_%0d: err=%b, required 1", vals[i], err); end
            if ({busy, sp_if.in_ready, step} !== 5'd0) begin
                mismatched++; $display("FAIL invalid_quiet_%0d: busy/ready/step=%b, required 0", vals[i], {busy, sp_if.in_ready, step});
            end
            @(posedge clk); #1;
            compared++;
            if ({err, busy, step} !== 5'd0) begin mismatched++; $display("FAIL invalid_after_%0d: err/busy/step=%b, required 0", vals[i], {err, busy, step}); end
        end
        sp_if.in_valid = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int d;
        wait_idle();
        run_load(2, 0, 3, -1);
        build_expected(2);
        d = first_diff();
        compared += 3;
        if (obs.size() != 260 || d != -1) begin mismatched++; $display("FAIL busy_start_writes: got %0d writes (first diff %0d), required 260 (-1)", obs.size(), d); end
        if (done_cnt != 1 || timed_out) begin mismatched++; $display("FAIL busy_start_done: got %0d, required 1", done_cnt); end
        if (err_cnt != 0) begin mismatched++; $display("FAIL busy_start_err: got %0d pulses, required 0", err_cnt); end
    endtask

    task automatic test_phase_boundary();
        int n = $urandom_range(1, 5);
        int k = 2 * SYS_H * n;
        wait_idle();
        run_load(n, 0, -1, -1);
        compared++;
        if (obs.size() < k + 1) begin
            mismatched++; $display("FAIL boundary_size: got %0d writes, required at least %0d", obs.size(), k + 1);
        end else begin
            compared += 2;
            if (obs[k-1].step != 1 || obs[k-1].addr != 1 || obs[k-1].layer != n - 1 || obs[k].cyc != obs[k-1].cyc + 1) begin
                mismatched++; $display("FAIL boundary_last_act: got s%0d a%0d l%0d, required s1 a1 l%0d", obs[k-1].step, obs[k-1].addr, obs[k-1].layer, n - 1);
            end
            if (obs[k].step != 2 || obs[k].num != 0 || obs[k].addr != 0 || obs[k].layer != 0 || obs[k].data !== words[k]) begin
                mismatched++; $display("FAIL boundary_first_wgt: got s%0d n%0d a%0d l%0d, required s2 n0 a0 l0", obs[k].step, obs[k].num, obs[k].addr, obs[k].layer);
            end
        end
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(1, 5);
            int d;
            wait_idle();
            run_load(n, 2, -1, -1);
            build_expected(n);
            d = first_diff();
            compared += 2;
            if (obs.size() != exp_q.size() || d != -1) begin
                mismatched++; $display("FAIL random_%0d_writes: got %0d writes (first diff %0d), required %0d (-1)", r, obs.size(), d, exp_q.size());
            end
            if (done_cnt != 1 || proto_errs != 0 || timed_out) begin
                mismatched++; $display("FAIL random_%0d_protocol: done %0d violations %0d, required 1 and 0", r, done_cnt, proto_errs);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [63:0] snap;
        int d;
        wait_idle();
        run_load(1, 0, -1, 40);
        rst_n = 1'b0;
        #1;
        snap = {step, act_bram_num, act_bram_addr, act_bram_layer, weight_bram_num,
                weight_bram_addr, weight_bram_layer, busy, done, err, sp_if.in_ready, data_received};
        compared += 2;
        if (snap !== 64'd0) begin mismatched++; $display("FAIL midreset_outputs: got %h, required 0", snap); end
        if (done_cnt != 0) begin mismatched++; $display("FAIL midreset_no_done: got %0d, required 0", done_cnt); end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL midreset_done_low: done=%b, required 0", done); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_load(1, 0, -1, -1);
        build_expected(1);
        d = first_diff();
        compared += 2;
        if (obs.size() != 130 || d != -1) begin mismatched++; $display("FAIL midreset_reload: got %0d writes (first diff %0d), required 130 (-1)", obs.size(), d); end
        if (done_cnt != 1 || timed_out) begin mismatched++; $display("FAIL midreset_reload_done: got %0d, required 1", done_cnt); end
    endtask

    initial begin
        sp_if.in_valid = 1'b0;
        sp_if.in_data  = 32'd0;
        test_reset();
        test_single_layer();
        test_five_layers_toggle();
        test_invalid_start();
        test_start_while_busy();
        test_phase_boundary();
        test_random_loads();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
